cache_flush_engine: RTL and testbench

Write-back/flush controller for the direct-mapped data cache: 16 lines, one 32-bit word per line, tag = address[31:6], index = address[5:2]. It walks one line or all lines, re-encodes each valid+dirty line's tag and index into a full byte address, and issues a memory write over a valid/ready handshake. Each dirty bit is cleared once its write is accepted. It sits between the cache line arrays and the data-memory write port, and is the encode-side counterpart of the cache address decode.

---
 rtl/cache_pkg.sv | 30 +++
 rtl/cache_flush_engine_if.sv | 25 ++
 rtl/cache_addr_encode.sv | 12 +
 rtl/cache_flush_engine.sv | 112 +++++++++++
 tb/tb_cache_flush_engine.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared geometry, FSM state type and address encoder for the direct-mapped data cache.
// Both the decode side and the flush engine import these widths so they always agree.
package cache_pkg;

    localparam int TAG_W    = 26;
    localparam int INDEX_W  = 4;
    localparam int OFFSET_W = 2;
    localparam int LINES    = 16;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 32;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        WRITE,
        ADVANCE,
        DONE
    } flush_state_t;

    typedef enum logic {
        MODE_ONE,
        MODE_ALL
    } flush_mode_t;

    function automatic logic [ADDR_W-1:0] encode_addr(input logic [TAG_W-1:0]   tag,
                                                      input logic [INDEX_W-1:0] index);
        return {tag, index, {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/cache_flush_engine_if.sv
// Data-memory write port: valid/ready handshake carrying one word and its byte address.
interface cache_flush_engine_if #(
    parameter int DATA_W = 32
);

    logic              oMemWrValid;
    logic              iMemWrReady;
    logic [31:0]       oMemWrAddr;
    logic [DATA_W-1:0] oMemWrData;

    modport master (
        output oMemWrValid,
        output oMemWrAddr,
        output oMemWrData,
        input  iMemWrReady
    );

    modport slave (
        input  oMemWrValid,
        input  oMemWrAddr,
        input  oMemWrData,
        output iMemWrReady
    );

endinterface

// File: rtl/cache_addr_encode.sv
// Rebuilds a full byte address from a line's stored tag and its index.
module cache_addr_encode
    import cache_pkg::*;
(
    input  logic [TAG_W-1:0]   iTag,
    input  logic [INDEX_W-1:0] iIndex,
    output logic [ADDR_W-1:0]  oAddr
);

    assign oAddr = encode_addr(iTag, iIndex);

endmodule

// File: rtl/cache_flush_engine.sv
// Walks one or all cache lines and writes every valid+dirty line back to data memory,
// clearing its dirty bit once the memory accepts the write.
module cache_flush_engine #(
    parameter int TAG_W   = 26,
    parameter int INDEX_W = 4,
    parameter int DATA_W  = 32
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic               iFlushAll,
    input  logic               iFlushOne,
    input  logic [31:0]        iFlushAddress,
    output logic               oBusy,
    output logic               oDone,
    output logic [INDEX_W-1:0] oLineIndex,
    input  logic               iLineValid,
    input  logic               iLineDirty,
    input  logic [TAG_W-1:0]   iLineTag,
    input  logic [DATA_W-1:0]  iLineData,
    output logic               oClearDirty,
    cache_flush_engine_if.master mem_wr
);

    import cache_pkg::*;

    flush_state_t      state_q, state_d;
    flush_mode_t       mode_q,  mode_d;
    logic [INDEX_W-1:0] index_q, index_d;
    logic [31:0]       addr_q,  addr_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [31:0]       line_addr;

    cache_addr_encode u_addr_encode (
        .iTag   (iLineTag),
        .iIndex (index_q),
        .oAddr  (line_addr)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge value of the others; blocking here would create order-dependent races.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= IDLE;
            mode_q  <= MODE_ONE;
            index_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            index_q <= index_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // NOTE: every variable gets its hold value first, so no branch can leave one
    // unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        index_d = index_q;
        addr_d  = addr_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                if (iFlushAll) begin
                    index_d = '0;
                    mode_d  = MODE_ALL;
                    state_d = SCAN;
                end else if (iFlushOne) begin
                    index_d = iFlushAddress[OFFSET_W +: INDEX_W];
                    mode_d  = MODE_ONE;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (iLineValid && iLineDirty) begin
                    addr_d  = line_addr;
                    data_d  = iLineData;
                    state_d = WRITE;
                end else begin
                    state_d = ADVANCE;
                end
            end
            WRITE: begin
                if (mem_wr.iMemWrReady) state_d = ADVANCE;
            end
            ADVANCE: begin
                // Last line ends the walk instead of wrapping back to index 0.
                if (mode_q == MODE_ONE || index_q == '1) begin
                    state_d = DONE;
                end else begin
                    index_d = index_q + 1'b1;
                    state_d = SCAN;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign oBusy              = (state_q != IDLE);
    assign oDone              = (state_q == DONE);
    assign oLineIndex         = index_q;
    assign mem_wr.oMemWrValid = (state_q == WRITE);
    assign mem_wr.oMemWrAddr  = addr_q;
    assign mem_wr.oMemWrData  = data_q;
    // A reset landing on the handshake cycle must leave the line dirty.
    assign oClearDirty        = (state_q == WRITE) && mem_wr.iMemWrReady && !iRst;

endmodule

// File: tb/tb_cache_flush_engine.sv
// Randomized self-checking bench: a line-array model plus a flush-level reference that
// predicts writes, their addresses, handshake length and completion cycle.
module tb_cache_flush_engine;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iFlushAll, iFlushOne;
    logic [31:0] iFlushAddress;
    logic        oBusy, oDone, oClearDirty;
    logic [3:0]  oLineIndex;
    logic        iLineValid, iLineDirty;
    logic [25:0] iLineTag;
    logic [31:0] iLineData;

    cache_flush_engine_if #(.DATA_W(32)) mem_wr ();

    cache_flush_engine dut (
        .iClk          (iClk),
        .iRst          (iRst),
        .iFlushAll     (iFlushAll),
        .iFlushOne     (iFlushOne),
        .iFlushAddress (iFlushAddress),
        .oBusy         (oBusy),
        .oDone         (oDone),
        .oLineIndex    (oLineIndex),
        .iLineValid    (iLineValid),
        .iLineDirty    (iLineDirty),
        .iLineTag      (iLineTag),
        .iLineData     (iLineData),
        .oClearDirty   (oClearDirty),
        .mem_wr        (mem_wr)
    );

    always #5 iClk = ~iClk;

    bit          vld [16];
    bit          drt [16];
    logic [25:0] tg  [16];
    logic [31:0] dt  [16];

    assign iLineValid = vld[oLineIndex];
    assign iLineDirty = drt[oLineIndex];
    assign iLineTag   = tg[oLineIndex];
    assign iLineData  = dt[oLineIndex];

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] dirty_mask();
        logic [15:0] m;
        for (int i = 0; i < 16; i++) m[i] = drt[i];
        return m;
    endfunction

    task automatic fill_lines(input int dirty_pct);
        for (int i = 0; i < 16; i++) begin
            vld[i] = ($urandom_range(0, 99) < 70);
            drt[i] = ($urandom_range(0, 99) < dirty_pct);
            tg[i]  = 26'($urandom);
            dt[i]  = $urandom;
        end
    endtask

    // Runs one flush request and checks it against the reference model. fixed_stall<0
    // picks a random number of ready-low cycles per write. pulse_at>0 pulses iFlushOne
    // in that cycle to probe that busy-time requests are ignored.
    task automatic run_flush(input bit all, input bit one, input logic [31:0] faddr,
                             input int fixed_stall, input int pulse_at, output int done_out);
        int          lines[$];
        int          wr_idx[$];
        int          stalls[$];
        int          visits[$];
        int          exp_cycles, exp_valid;
        logic [15:0] exp_dirty;
        int          wn, cur_stall, valid_cycles, clears, dones, done_cyc, l;
        bit          in_write;
        logic [31:0] ea;

        if (all) for (int i = 0; i < 16; i++) lines.push_back(i);
        else     lines.push_back(int'(faddr[5:2]));
        exp_dirty  = dirty_mask();
        exp_cycles = 2 * lines.size() + 1;
        exp_valid  = 0;
        foreach (lines[k]) begin
            l = lines[k];
            if (vld[l] && drt[l]) begin
                wr_idx.push_back(l);
                stalls.push_back(fixed_stall >= 0 ? fixed_stall : int'($urandom_range(0, 3)));
                exp_cycles += 1 + stalls[$];
                exp_valid  += 1 + stalls[$];
                exp_dirty[l] = 1'b0;
            end
        end

        iFlushAll     = all;
        iFlushOne     = one;
        iFlushAddress = faddr;
        @(posedge iClk); #1;
        iFlushAll     = 1'b0;
        iFlushOne     = 1'b0;
        iFlushAddress = $urandom;

        wn = 0; cur_stall = 0; in_write = 0; valid_cycles = 0; clears = 0;
        dones = 0; done_cyc = -1;
        for (int c = 1; c <= 400; c++) begin
            iFlushOne = (c == pulse_at);
            if (mem_wr.oMemWrValid) begin
                if (!in_write) begin
                    in_write  = 1;
                    cur_stall = (wn < stalls.size()) ? stalls[wn] : 0;
                    wn++;
                end
                mem_wr.iMemWrReady = (cur_stall == 0);
                if (cur_stall > 0) cur_stall--;
            end else begin
                mem_wr.iMemWrReady = 1'($urandom_range(0, 1));
            end
            #1;
            if (mem_wr.oMemWrValid) begin
                valid_cycles++;
                if (wn <= wr_idx.size()) begin
                    l  = wr_idx[wn-1];
                    ea = 32'(tg[l]) * 32'd64 + 32'(l) * 32'd4;
                    check("wr_addr", mem_wr.oMemWrAddr, ea);
                    check("wr_data", mem_wr.oMemWrData, dt[l]);
                end
            end
            if (oClearDirty) begin
                clears++;
                check("clr_ready", mem_wr.iMemWrReady, 1'b1);
                if (wn >= 1 && wn <= wr_idx.size()) check("clr_index", oLineIndex, wr_idx[wn-1]);
                drt[oLineIndex] = 1'b0;
                in_write = 0;
            end
            if (oBusy && (visits.size() == 0 || visits[$] != int'(oLineIndex)))
                visits.push_back(int'(oLineIndex));
            if (oDone) begin
                dones++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (done_cyc > 0 && c == done_cyc + 1) begin
                check("busy_after_done", oBusy, 1'b0);
                break;
            end
            @(posedge iClk); #1;
        end
        iFlushOne          = 1'b0;
        mem_wr.iMemWrReady = 1'b0;

        check("done_cycle", done_cyc, exp_cycles);
        check("done_pulses", dones, 1);
        check("write_count", wn, wr_idx.size());
        check("valid_cycles", valid_cycles, exp_valid);
        check("clear_count", clears, wr_idx.size());
        check("dirty_after", dirty_mask(), exp_dirty);
        check("visit_count", visits.size(), lines.size());
        for (int i = 0; i < visits.size() && i < lines.size(); i++)
            check("visit_order", visits[i], lines[i]);
        done_out = done_cyc;
    endtask

    int done_at;
    int waited;

    initial begin
        iRst = 1'b1; iFlushAll = 1'b0; iFlushOne = 1'b0; iFlushAddress = '0;
        mem_wr.iMemWrReady = 1'b1;
        fill_lines(50);
        repeat (2) @(posedge iClk);
        #1;
        check("rst_busy", oBusy, 1'b0);
        check("rst_done", oDone, 1'b0);
        check("rst_valid", mem_wr.oMemWrValid, 1'b0);
        check("rst_clear", oClearDirty, 1'b0);
        check("rst_index", oLineIndex, 4'd0);
        check("rst_addr", mem_wr.oMemWrAddr, 32'd0);
        check("rst_data", mem_wr.oMemWrData, 32'd0);
        iRst = 1'b0;
        mem_wr.iMemWrReady = 1'b0;
        @(posedge iClk); #1;

        // Fully clean cache: pure walk.
        for (int i = 0; i < 16; i++) drt[i] = 1'b0;
        run_flush(1, 0, 32'h0, 0, 0, done_at);
        check("clean_all_done", done_at, 33);

        // One dirty line, ready always high.
        vld[5] = 1'b1; drt[5] = 1'b1; tg[5] = 26'h0ABCDEF; dt[5] = 32'hDEADBEEF;
        run_flush(1, 0, 32'h0, 0, 0, done_at);
        check("line5_done", done_at, 34);

        // Single-line flush with a 4-cycle memory stall.
        vld[15] = 1'b1; drt[15] = 1'b1;
        run_flush(0, 1, 32'h0000003C, 4, 0, done_at);
        check("line15_done", done_at, 8);

        // Valid clear but dirty set: skipped, stays dirty.
        vld[3] = 1'b0; drt[3] = 1'b1;
        run_flush(0, 1, 32'h0000000C, 0, 0, done_at);
        check("line3_done", done_at, 3);

        // Simultaneous requests, plus a request while busy.
        fill_lines(60);
        run_flush(1, 1, 32'h00000024, -1, 10, done_at);

        // Reset during a stalled write leaves the line dirty.
        vld[7] = 1'b1; drt[7] = 1'b1;
        iFlushOne = 1'b1; iFlushAddress = 32'h0000001C; mem_wr.iMemWrReady = 1'b0;
        @(posedge iClk); #1;
        iFlushOne = 1'b0;
        waited = 0;
        while (!mem_wr.oMemWrValid && waited < 10) begin
            @(posedge iClk); #1;
            waited++;
        end
        check("rst_mid_reach_write", mem_wr.oMemWrValid, 1'b1);
        @(posedge iClk); #1;
        iRst = 1'b1;
        mem_wr.iMemWrReady = 1'b1;
        #1;
        check("rst_mid_no_clear", oClearDirty, 1'b0);
        @(posedge iClk); #1;
        iRst = 1'b0;
        mem_wr.iMemWrReady = 1'b0;
        check("rst_mid_valid", mem_wr.oMemWrValid, 1'b0);
        check("rst_mid_busy", oBusy, 1'b0);
        check("rst_mid_dirty", drt[7], 1'b1);
        run_flush(0, 1, 32'h0000001C, 0, 0, done_at);
        check("rst_mid_rewrite", drt[7], 1'b0);

        // Randomized flushes.
        for (int n = 0; n < 12; n++) begin
            bit ra, ro;
            fill_lines(int'($urandom_range(20, 80)));
            ra = 1'($urandom_range(0, 1));
            ro = ra ? 1'($urandom_range(0, 1)) : 1'b1;
            run_flush(ra, ro, $urandom, -1, ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 12)) : 0,
                      done_at);
            repeat (int'($urandom_range(0, 2))) @(posedge iClk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
